// File: rtl/master_arbiter_link.sv
// Master-side serial link to the bus arbiter: sends REQUEST/RELEASE command frames
// and decodes ACK/WAIT/CLEAR response frames into grant, preempt and timeout status.
module master_arbiter_link #(
    parameter int unsigned NO_SLAVES   = 3,
    parameter int unsigned S_ID_WIDTH  = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] slave_id,
    input  logic                  done,
    input  logic                  arb_in,
    output logic                  arb_out,
    output logic                  granted,
    output logic                  busy,
    output logic                  preempted,
    output logic                  timeout
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
    localparam int unsigned PAY_W = 2 + S_ID_WIDTH;
    localparam int unsigned BIT_W = $clog2(PAY_W + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] PAY_BITS = BIT_W'(PAY_W);
    localparam logic [1:0] CMD_REQ   = 2'b01;
    localparam logic [1:0] CMD_REL   = 2'b10;
    localparam logic [1:0] RSP_ACK   = 2'b11;
    localparam logic [1:0] RSP_WAIT  = 2'b01;
    localparam logic [1:0] RSP_CLEAR = 2'b00;

    if (2 ** S_ID_WIDTH <= NO_SLAVES) begin : g_cfg_err
        $error("S_ID_WIDTH too narrow to address NO_SLAVES");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_REQ, S_WAIT_ACK, S_GRANTED, S_SEND_REL
    } state_t;

    state_t                r_state;
    logic [S_ID_WIDTH-1:0] r_id;
    logic [PAY_W-1:0]      r_tx_sh;
    logic [BIT_W-1:0]      r_tx_left;
    logic [1:0]            r_rx_cnt;
    logic                  r_rsp_hi;
    logic [CNT_W-1:0]      r_to_cnt;
    logic                  r_done_pend;
    logic                  r_arb_out;
    logic                  r_granted;
    logic                  r_busy;
    logic                  r_preempted;
    logic                  r_timeout;

    logic       w_rx_active;
    logic       w_rx_done;
    logic [1:0] w_rsp;
    logic       w_done_req;

    assign w_rx_active = (r_state == S_WAIT_ACK) || (r_state == S_GRANTED);
    assign w_rx_done   = w_rx_active && (r_rx_cnt == 2'd2);
    assign w_rsp       = {r_rsp_hi, arb_in};
    assign w_done_req  = done | r_done_pend;

    assign arb_out   = r_arb_out;
    assign granted   = r_granted;
    assign busy      = r_busy;
    assign preempted = r_preempted;
    assign timeout   = r_timeout;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_tx_sh     <= '0;
            r_tx_left   <= '0;
            r_rx_cnt    <= '0;
            r_rsp_hi    <= 1'b0;
            r_to_cnt    <= '0;
            r_done_pend <= 1'b0;
            r_arb_out   <= 1'b0;
            r_granted   <= 1'b0;
            r_busy      <= 1'b0;
            r_preempted <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_preempted <= 1'b0;
            r_timeout   <= 1'b0;

            // Response receiver: start bit, then two payload bits.
            if (!w_rx_active) begin
                r_rx_cnt <= 2'd0;
            end else begin
                case (r_rx_cnt)
                    2'd0:    if (arb_in) r_rx_cnt <= 2'd1;
                    2'd1: begin
                        r_rsp_hi <= arb_in;
                        r_rx_cnt <= 2'd2;
                    end
                    default: r_rx_cnt <= 2'd0;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_id      <= slave_id;
                        r_arb_out <= 1'b1;
                        r_tx_sh   <= {CMD_REQ, slave_id};
                        r_tx_left <= PAY_BITS;
                        r_busy    <= 1'b1;
                        r_state   <= S_SEND_REQ;
                    end
                end
                S_SEND_REQ, S_SEND_REL: begin
                    if (r_tx_left != '0) begin
                        r_arb_out <= r_tx_sh[PAY_W-1];
                        r_tx_sh   <= {r_tx_sh[PAY_W-2:0], 1'b0};
                        r_tx_left <= r_tx_left - BIT_W'(1);
                    end else begin
                        r_arb_out <= 1'b0;
                        r_to_cnt  <= '0;
                        if (r_state == S_SEND_REQ) begin
                            r_state <= S_WAIT_ACK;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (w_rx_done) begin
                        if (w_rsp == RSP_ACK) begin
                            r_granted <= 1'b1;
                            r_state   <= S_GRANTED;
                        end else if (w_rsp == RSP_WAIT) begin
                            r_to_cnt <= '0;
                        end
                    end else if ((r_rx_cnt == 2'd0) && !arb_in) begin
                        if (r_to_cnt == CNT_MAX) begin
                            r_timeout <= 1'b1;
                            r_arb_out <= 1'b1;
                            r_tx_sh   <= {CMD_REL, r_id};
                            r_tx_left <= PAY_BITS;
                            r_state   <= S_SEND_REL;
                        end else begin
                            r_to_cnt <= r_to_cnt + CNT_W'(1);
                        end
                    end
                end
                S_GRANTED: begin
                    // A release arriving mid-payload waits for the frame to finish.
                    if (w_done_req && (r_rx_cnt == 2'd1)) begin
                        r_done_pend <= 1'b1;
                    end else if (w_done_req) begin
                        r_done_pend <= 1'b0;
                        r_granted   <= 1'b0;
                        r_arb_out   <= 1'b1;
                        r_tx_sh     <= {CMD_REL, r_id};
                        r_tx_left   <= PAY_BITS;
                        r_state     <= S_SEND_REL;
                    end else if (w_rx_done && (w_rsp == RSP_CLEAR)) begin
                        r_granted   <= 1'b0;
                        r_preempted <= 1'b1;
                        r_to_cnt    <= '0;
                        r_state     <= S_WAIT_ACK;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/master_arbiter_link.md
Name: master_arbiter_link

Overview:
- Master-side counterpart of the arbiter's per-master serial port.
- Turns the master's parallel bus request and release into serial command frames on the arbiter link.
- Decodes the serial response frames the arbiter returns into grant, preempt and timeout status.
- One instance per master; `arb_out` drives arbiter `portN_in` and `arb_in` receives arbiter `portN_out`.

Parameters:
- NO_SLAVES, 3, number of slaves addressable on the bus.
- S_ID_WIDTH, 2, slave id width; must satisfy 2**S_ID_WIDTH > NO_SLAVES.
- ACK_TIMEOUT, 64, maximum cycles in WAIT_ACK without a response start bit before the request is withdrawn.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- req  in  1  bus request; sampled only in IDLE.
- slave_id  in  S_ID_WIDTH  target slave, latched with req.
- done  in  1  release bus; honoured only in GRANTED.
- arb_in  in  1  serial response from the arbiter.
- arb_out  out  1  serial command to the arbiter; idles low.
- granted  out  1  master owns the bus.
- busy  out  1  high in every state except IDLE.
- preempted  out  1  one-cycle pulse when the grant is revoked.
- timeout  out  1  one-cycle pulse when the ack wait expires.

Behaviour:
- Reset is asynchronous. All outputs go to 0 and the FSM goes to IDLE, including mid-frame. The latched id and all counters clear.
- Command frame, 5 bits, MSB-first, one bit per cycle:
  - start bit 1, then cmd[1:0], then id[1:0].
  - cmd 01 = REQUEST, cmd 10 = RELEASE.
  - arb_out is 0 outside frames.
- Response frame, 3 bits:
  - start bit 1 on arb_in, then rsp[1:0].
  - rsp 11 = ACK, 01 = WAIT, 00 = CLEAR, 10 = reserved (ignored).
  - The receiver samples arb_in every cycle, but only in WAIT_ACK and GRANTED. A 1 while the receiver is idle starts a frame; the next 2 cycles are the payload. A frame in progress is completed even if done arrives.
- FSM states: IDLE, SEND_REQ, WAIT_ACK, GRANTED, SEND_REL.
- IDLE:
  - req=1 latches slave_id and moves to SEND_REQ.
  - The start bit appears on arb_out in the first SEND_REQ cycle, i.e. the cycle after req is sampled.
  - done is ignored.
- SEND_REQ: 5 cycles, then WAIT_ACK; the timeout counter clears.
- WAIT_ACK:
  - Counter increments each cycle no response start bit is seen.
  - ACK: granted=1 in the cycle after the last payload bit is sampled; go to GRANTED.
  - WAIT: counter clears; stay in WAIT_ACK.
  - CLEAR: ignored.
  - Counter reaching ACK_TIMEOUT-1 with no start bit: timeout pulses for one cycle, then SEND_REL to withdraw the request.
- GRANTED:
  - done=1: granted falls the next cycle, the RELEASE frame starts on arb_out that same cycle, go to SEND_REL.
  - CLEAR completed: granted falls, preempted pulses for one cycle, go to WAIT_ACK. The request is not resent; the counter clears.
  - done asserted in the cycle a CLEAR completes: done wins; RELEASE is sent and preempted stays 0.
  - ACK or WAIT while granted: ignored.
- SEND_REL: 5 cycles, then IDLE. req is not sampled until IDLE; a new req is accepted in the first IDLE cycle.
- The latched id is used for both REQUEST and RELEASE, independent of later slave_id changes.
- Width rule: the timeout counter is $clog2(ACK_TIMEOUT) bits wide and saturates; it never wraps.

Test Plan:
- Reset, slave_id=2'b10, req pulse at cycle 0 → arb_out = 1,0,1,1,0 over cycles 1-5, busy=1 from cycle 1, granted=0.
- After the request, drive arb_in 1,1,1 → granted=1 the cycle after the third bit. Then done=1 → granted=0 next cycle and arb_out = 1,1,0,1,0, then IDLE with busy=0.
- In GRANTED, drive arb_in 1,0,0 → granted falls, preempted high exactly one cycle, state WAIT_ACK. Then 1,1,1 → re-granted with no new REQUEST frame on arb_out.
- ACK_TIMEOUT=8, no response → timeout pulse after 8 WAIT_ACK cycles, then RELEASE frame with the latched id. Repeat with a WAIT frame at cycle 5 → the counter restarts and timeout slips accordingly.
- Assert rstN=0 on the 3rd REQUEST bit → arb_out, granted and busy are 0 immediately. After release, req is accepted and the full frame is resent.
- done asserted in the same cycle a CLEAR payload completes → RELEASE frame sent, preempted=0. Separately, done in IDLE or WAIT_ACK → no frame on arb_out.
